// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE core controllers.
// rate_words() gives the last lane index of a squeeze block for the chosen mode.
package shake_pkg;

    localparam int NUM_ROUNDS     = 24;
    localparam int RATE_WORDS_128 = 21;
    localparam int RATE_WORDS_256 = 17;
    localparam int ROUND_W        = 5;

    typedef enum logic [2:0] {
        CLEAR,
        WAIT_BLOCK,
        ABSORB,
        PERMUTE,
        SQUEEZE
    } state_t;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } mode_t;

    function automatic logic [ROUND_W-1:0] rate_words(input mode_t mode);
        if (mode == SHAKE256) begin
            return ROUND_W'(RATE_WORDS_256 - 1);
        end
        return ROUND_W'(RATE_WORDS_128 - 1);
    endfunction

endpackage

// File: rtl/keccak_round_counter.sv
// Round counter for Keccak-f: steps once per enabled cycle and wraps to 0 after
// the final round, so it rests at 0 whenever no permutation is running.
module keccak_round_counter
    import shake_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    output logic [ROUND_W-1:0] round_idx,
    output logic               last_round
);

    logic [ROUND_W-1:0] round_idx_reg;

    assign last_round = (round_idx_reg == ROUND_W'(NUM_ROUNDS - 1));
    assign round_idx  = round_idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_idx_reg <= '0;
        end else if (clr) begin
            round_idx_reg <= '0;
        end else if (en) begin
            round_idx_reg <= last_round ? '0 : round_idx_reg + 1'b1;
        end
    end

endmodule

// File: rtl/permute_squeeze_fsm.sv
// Absorb/permute/squeeze sequencer of the SHAKE core. Drives only control strobes;
// the Keccak state, round function and output lane mux live in the datapath.
module permute_squeeze_fsm
    import shake_pkg::*;
#(
    parameter int OUT_LEN_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_i,
    input  logic [OUT_LEN_W-1:0] output_len_i,
    input  logic                 input_buffer_ready_wr,
    input  logic                 last_block_in_buffer_wr,
    output logic                 input_buffer_consumed,
    output logic                 state_clear,
    output logic                 absorb_enable,
    output logic                 round_enable,
    output logic [ROUND_W-1:0]   round_idx,
    output logic [ROUND_W-1:0]   out_word_idx,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o,
    output logic                 done
);

    state_t               state_reg, state_next;
    mode_t                mode_reg, mode_next;
    logic [OUT_LEN_W-1:0] words_left_reg, words_left_next;
    logic [ROUND_W-1:0]   out_word_idx_reg, out_word_idx_next;
    logic                 first_blk_reg, first_blk_next;
    logic                 is_last_reg, is_last_next;
    logic                 sq_perm_reg, sq_perm_next;
    logic                 done_pend_reg, done_pend_next;
    logic                 last_round;
    logic                 last_word;

    keccak_round_counter u_round_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (round_enable),
        .clr        (state_reg != PERMUTE),
        .round_idx  (round_idx),
        .last_round (last_round)
    );

    assign last_word = (words_left_reg == OUT_LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= CLEAR;
            mode_reg         <= SHAKE128;
            words_left_reg   <= '0;
            out_word_idx_reg <= '0;
            first_blk_reg    <= 1'b0;
            is_last_reg      <= 1'b0;
            sq_perm_reg      <= 1'b0;
            done_pend_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            mode_reg         <= mode_next;
            words_left_reg   <= words_left_next;
            out_word_idx_reg <= out_word_idx_next;
            first_blk_reg    <= first_blk_next;
            is_last_reg      <= is_last_next;
            sq_perm_reg      <= sq_perm_next;
            done_pend_reg    <= done_pend_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        mode_next         = mode_reg;
        words_left_next   = words_left_reg;
        out_word_idx_next = out_word_idx_reg;
        first_blk_next    = first_blk_reg;
        is_last_next      = is_last_reg;
        sq_perm_next      = sq_perm_reg;
        done_pend_next    = done_pend_reg;

        state_clear           = 1'b0;
        absorb_enable         = 1'b0;
        input_buffer_consumed = 1'b0;
        round_enable          = 1'b0;
        valid_o               = 1'b0;
        last_o                = 1'b0;
        done                  = 1'b0;

        case (state_reg)
            CLEAR: begin
                state_clear    = 1'b1;
                done           = done_pend_reg;
                done_pend_next = 1'b0;
                first_blk_next = 1'b1;
                state_next     = WAIT_BLOCK;
            end
            WAIT_BLOCK: begin
                if (input_buffer_ready_wr) begin
                    state_next = ABSORB;
                end
            end
            ABSORB: begin
                absorb_enable         = 1'b1;
                input_buffer_consumed = 1'b1;
                is_last_next          = last_block_in_buffer_wr;
                // Mode and length belong to the message, so only its first block sets them.
                if (first_blk_reg) begin
                    mode_next       = mode_t'(mode_i);
                    words_left_next = output_len_i;
                    first_blk_next  = 1'b0;
                end
                sq_perm_next = 1'b0;
                state_next   = PERMUTE;
            end
            PERMUTE: begin
                round_enable = 1'b1;
                if (last_round) begin
                    if (is_last_reg || sq_perm_reg) begin
                        if (words_left_reg == '0) begin
                            done_pend_next = 1'b1;
                            state_next     = CLEAR;
                        end else begin
                            out_word_idx_next = '0;
                            state_next        = SQUEEZE;
                        end
                    end else begin
                        state_next = WAIT_BLOCK;
                    end
                end
            end
            SQUEEZE: begin
                valid_o = 1'b1;
                last_o  = last_word;
                if (ready_i) begin
                    if (words_left_reg != '0) begin
                        words_left_next = words_left_reg - 1'b1;
                    end
                    out_word_idx_next = out_word_idx_reg + 1'b1;
                    // Finishing the message wins over running out of rate lanes.
                    if (last_word) begin
                        done_pend_next = 1'b1;
                        state_next     = CLEAR;
                    end else if (out_word_idx_reg == rate_words(mode_reg)) begin
                        sq_perm_next      = 1'b1;
                        out_word_idx_next = '0;
                        state_next        = PERMUTE;
                    end
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign out_word_idx = out_word_idx_reg;

endmodule

// File: tb/tb_permute_squeeze_fsm.sv
// Randomized bench: each message's blocks, rounds, word order and latency are
// predicted from block count, mode and output length, then compared cycle by cycle.
module tb_permute_squeeze_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode_i;
    logic [31:0] output_len_i;
    logic        input_buffer_ready_wr;
    logic        last_block_in_buffer_wr;
    logic        input_buffer_consumed;
    logic        state_clear;
    logic        absorb_enable;
    logic        round_enable;
    logic [4:0]  round_idx;
    logic [4:0]  out_word_idx;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    permute_squeeze_fsm #(.OUT_LEN_W(32)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .mode_i                  (mode_i),
        .output_len_i            (output_len_i),
        .input_buffer_ready_wr   (input_buffer_ready_wr),
        .last_block_in_buffer_wr (last_block_in_buffer_wr),
        .input_buffer_consumed   (input_buffer_consumed),
        .state_clear             (state_clear),
        .absorb_enable           (absorb_enable),
        .round_enable            (round_enable),
        .round_idx               (round_idx),
        .out_word_idx            (out_word_idx),
        .valid_o                 (valid_o),
        .ready_i                 (ready_i),
        .last_o                  (last_o),
        .done                    (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One message: nblk blocks, given mode/length, ready_i high with probability rdy_pct%.
    // abort_at >= 0 asserts rst when the first permutation reaches that round.
    task automatic run_msg(input int nblk, input bit mode, input int len,
                           input int rdy_pct, input int abort_at);
        int cyc = 0, given = 0, consumed = 0, delay, hs = 0;
        int rounds = 0, run = 0, last_abs = -1000, rate, exp_rounds;
        bit first_valid = 0, done_seen = 0, locked = 0;
        rate       = mode ? 17 : 21;
        exp_rounds = 24 * (nblk + ((len == 0) ? 0 : (len - 1) / rate));
        delay      = $urandom_range(0, 3);
        mode_i                  = mode;
        output_len_i            = len;
        ready_i                 = 1'b0;
        input_buffer_ready_wr   = 1'b0;
        last_block_in_buffer_wr = 1'b0;
        $display("msg: blocks=%0d mode=%0d len=%0d ready%%=%0d abort=%0d",
                 nblk, mode, len, rdy_pct, abort_at);
        while (!done_seen && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            // Once the first block has been absorbed, these inputs must be ignored.
            if (locked) begin
                mode_i       = 1'($urandom_range(0, 1));
                output_len_i = $urandom;
            end
            if (input_buffer_consumed) begin
                check("consume_ready", input_buffer_ready_wr, 1);
                check("consume_absorb", absorb_enable, 1);
                check("consume_not_permuting", run, 0);
                consumed++;
                given++;
                input_buffer_ready_wr = 1'b0;
                last_abs = cyc;
                locked   = 1;
                delay    = $urandom_range(0, 3);
            end else if (given < nblk) begin
                if (delay > 0) begin
                    delay--;
                end else begin
                    input_buffer_ready_wr   = 1'b1;
                    last_block_in_buffer_wr = (given == nblk - 1);
                end
            end
            if (round_enable) begin
                check("round_idx", round_idx, run);
                run++;
                rounds++;
                if (abort_at >= 0 && run - 1 == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check("abort_state_clear", state_clear, 1);
                    check("abort_round_enable", round_enable, 0);
                    check("abort_round_idx", round_idx, 0);
                    check("abort_valid", valid_o, 0);
                    @(negedge clk);
                    rst = 1'b0;
                    input_buffer_ready_wr = 1'b0;
                    return;
                end
            end else begin
                if (run != 0) begin
                    check("round_run_len", run, 24);
                end
                run = 0;
                check("idle_round_idx", round_idx, 0);
            end
            if (valid_o) begin
                if (!first_valid) begin
                    check("first_word_latency", cyc - last_abs, 25);
                    check("blocks_before_squeeze", consumed, nblk);
                    first_valid = 1;
                end
                check("out_word_idx", out_word_idx, hs % rate);
                check("last_o", last_o, hs == len - 1);
            end
            ready_i = ($urandom_range(0, 99) < rdy_pct);
            if (valid_o && ready_i) begin
                hs++;
            end
            if (done) begin
                done_seen = 1;
                check("done_words", hs, len);
                check("done_rounds", rounds, exp_rounds);
                check("done_blocks", consumed, nblk);
                check("done_state_clear", state_clear, 1);
            end
        end
        if (!done_seen) begin
            check("timeout_no_done", 0, 1);
        end
        ready_i = 1'b0;
        input_buffer_ready_wr = 1'b0;
    endtask

    initial begin
        int rp;
        rst                     = 1'b1;
        mode_i                  = 1'b0;
        output_len_i            = '0;
        input_buffer_ready_wr   = 1'b0;
        last_block_in_buffer_wr = 1'b0;
        ready_i                 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state_clear", state_clear, 1);
        check("rst_consumed", input_buffer_consumed, 0);
        check("rst_absorb", absorb_enable, 0);
        check("rst_round_enable", round_enable, 0);
        check("rst_round_idx", round_idx, 0);
        check("rst_out_word_idx", out_word_idx, 0);
        check("rst_valid", valid_o, 0);
        check("rst_last", last_o, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        run_msg(1, 1'b0, 4, 100, -1);
        run_msg(3, 1'b1, 2, 100, -1);
        run_msg(1, 1'b0, 23, 100, -1);
        run_msg(2, 1'b1, 20, 40, -1);
        run_msg(1, 1'b0, 0, 100, -1);
        run_msg(2, 1'b0, 5, 100, 10);
        run_msg(1, 1'b1, 3, 100, -1);
        for (int i = 0; i < 30; i++) begin
            rp = ($urandom_range(0, 2) == 0) ? 100 : $urandom_range(25, 90);
            run_msg($urandom_range(1, 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 45), rp, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
